trap_ctrl: RTL and testbench

//  Trap arbiter between the MEM stage and the CSR file. Each cycle it takes the exception flags of the

---
 rtl/trap_ctrl_pkg.sv | 40 ++++
 rtl/trap_ctrl_int_sync.sv | 34 +++
 rtl/trap_ctrl.sv | 173 +++++++++++++++++
 tb/tb_trap_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared trap codes, CSR bit positions, interrupt causes and FSM states
// for the MEM-stage trap arbiter.
package trap_ctrl_pkg;

   localparam logic [31:0] EXC_INT      = 32'h0000_0000;
   localparam logic [31:0] EXC_ECALL    = 32'h0000_0001;
   localparam logic [31:0] EXC_EBREAK   = 32'h0000_0002;
   localparam logic [31:0] EXC_TIMER    = 32'h0000_0003;
   localparam logic [31:0] EXC_OV       = 32'h0000_0004;
   localparam logic [31:0] EXC_INST_INV = 32'h0000_0005;
   localparam logic [31:0] EXC_LD_MIS   = 32'h0000_0006;
   localparam logic [31:0] EXC_ST_MIS   = 32'h0000_0007;
   localparam logic [31:0] EXC_MRET     = 32'hFFFF_FFFF;
   localparam logic [31:0] EXC_NONE     = 32'h0000_000F;

   localparam int          MSTATUS_MIE    = 3;
   localparam logic [1:0]  MTVEC_MODE_VEC = 2'd1;

   localparam logic [31:0] CAUSE_TIMER = 32'd7;
   localparam logic [31:0] CAUSE_EXT   = 32'd11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRAP  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // Redirect target for a non-MRET trap; only interrupts use the vectored
   // table, and the reserved modes 2/3 fall back to direct.
   function automatic logic [31:0] trap_vector(input logic [31:0] mtvec,
                                               input logic        is_int,
                                               input logic [31:0] cause);
      logic [31:0] base;
      base = {mtvec[31:2], 2'b00};
      if (is_int && (mtvec[1:0] == MTVEC_MODE_VEC))
         return base + (cause << 2);
      return base;
   endfunction

endpackage

// File: rtl/trap_ctrl_int_sync.sv
// Multi-flop synchronizer for an asynchronous interrupt request, producing a
// single-cycle pulse on each rising edge of the synchronized level.
module trap_ctrl_int_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   last_q, last_d;

   // Shift the raw input through the chain and remember the previous output.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
      last_d = sync_q[SYNC_STAGES-1];
   end

   // Chain and edge-detect registers, cleared on reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q <= '0;
         last_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         last_q <= last_d;
      end
   end

   assign rise_o = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/trap_ctrl.sv
// Trap arbiter between MEM and the CSR file: picks at most one trap per
// cycle, reports it to the CSR file and redirects the pipeline.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | accepting; arbitrates when the MEM slot is valid
// ST_TRAP  | registered trap outputs and flush visible for one cycle
// ST_DRAIN | pipeline bubbles; flags ignored for DRAIN_CYCLES cycles
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 2,   // at least 1
   parameter int SYNC_STAGES  = 2    // at least 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid_i,
   input  logic [31:0] mem_pc_i,
   input  logic [31:0] mem_inst_i,
   input  logic        exc_inst_inv_i,
   input  logic        exc_ecall_i,
   input  logic        exc_ebreak_i,
   input  logic        exc_ld_mis_i,
   input  logic        exc_st_mis_i,
   input  logic        exc_ov_i,
   input  logic        mret_i,
   input  logic        timer_int_i,
   input  logic        ext_int_i,
   input  logic [31:0] mstatus_i,
   input  logic [31:0] mtvec_i,
   input  logic [31:0] mepc_i,
   output logic [31:0] excepttype_o,
   output logic [31:0] current_inst_addr_o,
   output logic [31:0] inst_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o
);

   localparam int               CNT_W      = $clog2(DRAIN_CYCLES + 1);
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
   logic              int_pend_q, int_pend_d;
   logic [31:0]       excepttype_q, excepttype_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       inst_q, inst_d;
   logic [31:0]       new_pc_q, new_pc_d;
   logic              flush_q, flush_d;

   logic              ext_rise;
   logic              mie;
   logic              sel_valid;
   logic              sel_int;
   logic              sel_ext;
   logic [31:0]       sel_code;
   logic [31:0]       sel_cause;
   logic              unused_mstatus;

   assign unused_mstatus = ^{mstatus_i[31:MSTATUS_MIE+1], mstatus_i[MSTATUS_MIE-1:0]};
   assign mie            = mstatus_i[MSTATUS_MIE];

   trap_ctrl_int_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_int_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (ext_int_i),
      .rise_o  (ext_rise)
   );

   // Fixed-priority trap selection, only while idle with a real instruction.
   always_comb begin
      sel_valid = 1'b0;
      sel_int   = 1'b0;
      sel_ext   = 1'b0;
      sel_code  = EXC_NONE;
      sel_cause = '0;
      if (state_q == ST_IDLE && mem_valid_i) begin
         sel_valid = 1'b1;
         if      (exc_inst_inv_i)      sel_code = EXC_INST_INV;
         else if (exc_ecall_i)         sel_code = EXC_ECALL;
         else if (exc_ebreak_i)        sel_code = EXC_EBREAK;
         else if (exc_ld_mis_i)        sel_code = EXC_LD_MIS;
         else if (exc_st_mis_i)        sel_code = EXC_ST_MIS;
         else if (exc_ov_i)            sel_code = EXC_OV;
         else if (timer_int_i && mie) begin
            sel_code  = EXC_TIMER;
            sel_int   = 1'b1;
            sel_cause = CAUSE_TIMER;
         end else if (int_pend_q && mie) begin
            sel_code  = EXC_INT;
            sel_int   = 1'b1;
            sel_ext   = 1'b1;
            sel_cause = CAUSE_EXT;
         end else if (mret_i)          sel_code = EXC_MRET;
         else                          sel_valid = 1'b0;
      end
   end

   // A new edge beats a take in the same cycle so no request is lost.
   always_comb begin
      int_pend_d = int_pend_q;
      if (ext_rise)     int_pend_d = 1'b1;
      else if (sel_ext) int_pend_d = 1'b0;
   end

   // Next state and drain down-counter.
   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      unique case (state_q)
         ST_IDLE:  if (sel_valid) state_d = ST_TRAP;
         ST_TRAP: begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
         end
         ST_DRAIN: begin
            if (drain_cnt_q == '0) state_d = ST_IDLE;
            else                   drain_cnt_d = drain_cnt_q - 1'b1;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // Trap outputs are captured with the selection and shown for one cycle;
   // PC/instruction/target hold their last trap value otherwise.
   always_comb begin
      excepttype_d = EXC_NONE;
      flush_d      = 1'b0;
      addr_d       = addr_q;
      inst_d       = inst_q;
      new_pc_d     = new_pc_q;
      if (sel_valid) begin
         excepttype_d = sel_code;
         flush_d      = 1'b1;
         addr_d       = mem_pc_i;
         inst_d       = mem_inst_i;
         new_pc_d     = (sel_code == EXC_MRET) ? mepc_i
                                               : trap_vector(mtvec_i, sel_int, sel_cause);
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         drain_cnt_q  <= '0;
         int_pend_q   <= 1'b0;
         excepttype_q <= EXC_NONE;
         flush_q      <= 1'b0;
         addr_q       <= '0;
         inst_q       <= '0;
         new_pc_q     <= '0;
      end else begin
         state_q      <= state_d;
         drain_cnt_q  <= drain_cnt_d;
         int_pend_q   <= int_pend_d;
         excepttype_q <= excepttype_d;
         flush_q      <= flush_d;
         addr_q       <= addr_d;
         inst_q       <= inst_d;
         new_pc_q     <= new_pc_d;
      end
   end

   assign excepttype_o        = excepttype_q;
   assign flush_o             = flush_q;
   assign current_inst_addr_o = addr_q;
   assign inst_o              = inst_q;
   assign new_pc_o            = new_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_trap_ctrl;

   localparam int DRAIN = 2;
   localparam int SYNC  = 2;
   localparam logic [31:0] C_NONE = 32'h0000_000F;
   localparam logic [31:0] C_MRET = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid_i;
   logic [31:0] mem_pc_i, mem_inst_i;
   logic        exc_inst_inv_i, exc_ecall_i, exc_ebreak_i;
   logic        exc_ld_mis_i, exc_st_mis_i, exc_ov_i, mret_i;
   logic        timer_int_i, ext_int_i;
   logic [31:0] mstatus_i, mtvec_i, mepc_i;
   logic [31:0] excepttype_o, current_inst_addr_o, inst_o, new_pc_o;
   logic        flush_o;

   always #5 clk = ~clk;

   trap_ctrl #(.DRAIN_CYCLES(DRAIN), .SYNC_STAGES(SYNC)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .mem_valid_i         (mem_valid_i),
      .mem_pc_i            (mem_pc_i),
      .mem_inst_i          (mem_inst_i),
      .exc_inst_inv_i      (exc_inst_inv_i),
      .exc_ecall_i         (exc_ecall_i),
      .exc_ebreak_i        (exc_ebreak_i),
      .exc_ld_mis_i        (exc_ld_mis_i),
      .exc_st_mis_i        (exc_st_mis_i),
      .exc_ov_i            (exc_ov_i),
      .mret_i              (mret_i),
      .timer_int_i         (timer_int_i),
      .ext_int_i           (ext_int_i),
      .mstatus_i           (mstatus_i),
      .mtvec_i             (mtvec_i),
      .mepc_i              (mepc_i),
      .excepttype_o        (excepttype_o),
      .current_inst_addr_o (current_inst_addr_o),
      .inst_o              (inst_o),
      .flush_o             (flush_o),
      .new_pc_o            (new_pc_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_exc, m_pc, m_inst, m_npc;
   bit          m_flush, m_clear, m_pend;
   int          m_blocked;           // cycles left during which nothing is accepted
   bit          hist [0:SYNC];       // ext_int_i as seen at the last SYNC+1 edges
   logic [31:0] code_tab [9] = '{32'd5, 32'd1, 32'd2, 32'd6, 32'd7, 32'd4, 32'd3, 32'd0, 32'hFFFF_FFFF};

   task automatic model_step();
      bit          req [9];
      bit          mie, rise;
      int          pick;
      logic [31:0] base;
      if (!rst) begin
         m_exc = C_NONE; m_flush = 0; m_pc = 0; m_inst = 0; m_npc = 0;
         m_clear = 1; m_pend = 0; m_blocked = 0;
         for (int i = 0; i <= SYNC; i++) hist[i] = 0;
      end else begin
         mie  = mstatus_i[3];
         rise = hist[SYNC-1] && !hist[SYNC];
         req[0] = exc_inst_inv_i; req[1] = exc_ecall_i;  req[2] = exc_ebreak_i;
         req[3] = exc_ld_mis_i;   req[4] = exc_st_mis_i; req[5] = exc_ov_i;
         req[6] = timer_int_i && mie; req[7] = m_pend && mie; req[8] = mret_i;
         pick = -1;
         if (m_blocked == 0 && mem_valid_i)
            for (int i = 0; i < 9; i++) if (req[i] && pick < 0) pick = i;
         if (pick >= 0) begin
            m_exc = code_tab[pick]; m_flush = 1; m_clear = 0;
            m_pc = mem_pc_i; m_inst = mem_inst_i;
            base = {mtvec_i[31:2], 2'b00};
            if (pick == 8)                                 m_npc = mepc_i;
            else if (pick >= 6 && mtvec_i[1:0] == 2'd1)    m_npc = base + 4 * ((pick == 6) ? 7 : 11);
            else                                           m_npc = base;
            m_blocked = 1 + DRAIN;
         end else begin
            m_exc = C_NONE; m_flush = 0;
            if (m_blocked > 0) m_blocked--;
         end
         if (rise)           m_pend = 1;
         else if (pick == 7) m_pend = 0;
         for (int i = SYNC; i >= 1; i--) hist[i] = hist[i-1];
         hist[0] = ext_int_i;
      end
   endtask

   // Compare process: model advances on each edge, DUT sampled 1 unit later.
   always @(posedge clk) begin
      model_step();
      #1;
      check32("m_excepttype", excepttype_o, m_exc);
      check32("m_flush", {31'b0, flush_o}, {31'b0, m_flush});
      if (m_flush || m_clear) begin
         check32("m_addr", current_inst_addr_o, m_pc);
         check32("m_inst", inst_o, m_inst);
         check32("m_new_pc", new_pc_o, m_npc);
      end
   end

   // ---------------- directed + random stimulus ----------------
   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic clear_flags();
      exc_inst_inv_i = 0; exc_ecall_i = 0; exc_ebreak_i = 0; exc_ld_mis_i = 0;
      exc_st_mis_i = 0; exc_ov_i = 0; mret_i = 0;
   endtask

   task automatic settle(input int n);
      @(negedge clk); clear_flags(); mem_valid_i = 0; timer_int_i = 0;
      repeat (n) tick();
   endtask

   initial begin
      rst = 0; mem_valid_i = 0; mem_pc_i = 0; mem_inst_i = 0; clear_flags();
      timer_int_i = 0; ext_int_i = 0; mstatus_i = 0; mtvec_i = 0; mepc_i = 0;
      tick();
      check32("rst_code", excepttype_o, C_NONE);
      check32("rst_flush", {31'b0, flush_o}, 32'd0);
      check32("rst_new_pc", new_pc_o, 32'd0);
      check32("rst_addr", current_inst_addr_o, 32'd0);
      check32("rst_inst", inst_o, 32'd0);

      // 1: ECALL, direct mtvec, then two drain cycles of NONE
      @(negedge clk); rst = 1; mtvec_i = 32'h100; mem_valid_i = 1;
      mem_pc_i = 32'h40; mem_inst_i = 32'h0000_0073; exc_ecall_i = 1;
      tick();
      check32("t1_code", excepttype_o, 32'd1);
      check32("t1_addr", current_inst_addr_o, 32'h40);
      check32("t1_flush", {31'b0, flush_o}, 32'd1);
      check32("t1_new_pc", new_pc_o, 32'h100);
      @(negedge clk); clear_flags(); mem_valid_i = 0;
      tick(); check32("t1_drain0", excepttype_o, C_NONE);
      tick(); check32("t1_drain1", excepttype_o, C_NONE);
      settle(3);

      // 2: priority INST_INV over OV and timer; timer taken after drain
      @(negedge clk); mstatus_i = 32'h8; timer_int_i = 1; mem_valid_i = 1;
      mem_pc_i = 32'h50; mem_inst_i = 32'hFFFF_FFFF; exc_inst_inv_i = 1; exc_ov_i = 1;
      tick();
      check32("t2_code", excepttype_o, 32'd5);
      check32("t2_inst", inst_o, 32'hFFFF_FFFF);
      @(negedge clk); clear_flags();
      repeat (3) begin tick(); check32("t2_gap", excepttype_o, C_NONE); end
      tick();
      check32("t2_timer", excepttype_o, 32'd3);
      check32("t2_timer_pc", new_pc_o, 32'h100);
      settle(4);

      // 3: ext interrupt blocked by MIE=0, then taken vectored
      @(negedge clk); mstatus_i = 0; ext_int_i = 1; mem_valid_i = 1; mem_pc_i = 32'h80;
      @(negedge clk); ext_int_i = 0;
      repeat (6) begin tick(); check32("t3_masked", excepttype_o, C_NONE); end
      @(negedge clk); mstatus_i = 32'h8; mtvec_i = 32'h201;
      tick();
      check32("t3_code", excepttype_o, 32'd0);
      check32("t3_new_pc", new_pc_o, 32'h22C);
      check32("t3_addr", current_inst_addr_o, 32'h80);
      @(negedge clk); mstatus_i = 0;
      settle(4);

      // 4: MRET to mepc; flags during drain are ignored
      @(negedge clk); mret_i = 1; mepc_i = 32'h44; mem_valid_i = 1;
      tick();
      check32("t4_code", excepttype_o, C_MRET);
      check32("t4_new_pc", new_pc_o, 32'h44);
      @(negedge clk); mret_i = 0; exc_ecall_i = 1; exc_inst_inv_i = 1;
      repeat (3) begin tick(); check32("t4_drain", excepttype_o, C_NONE); end
      @(negedge clk); clear_flags();
      tick(); check32("t4_idle", excepttype_o, C_NONE);
      settle(3);

      // 5: reset during TRAP aborts everything, including a pending interrupt
      @(negedge clk); mstatus_i = 0; ext_int_i = 1;
      @(negedge clk); ext_int_i = 0;
      repeat (4) tick();
      @(negedge clk); mem_valid_i = 1; mem_pc_i = 32'h90; exc_ecall_i = 1;
      tick(); check32("t5_trap", {31'b0, flush_o}, 32'd1);
      @(negedge clk); rst = 0; clear_flags();
      tick();
      check32("t5_flush", {31'b0, flush_o}, 32'd0);
      check32("t5_code", excepttype_o, C_NONE);
      check32("t5_new_pc", new_pc_o, 32'd0);
      @(negedge clk); rst = 1; mstatus_i = 32'h8;
      repeat (4) begin tick(); check32("t5_no_pend", excepttype_o, C_NONE); end
      @(negedge clk); exc_ecall_i = 1;
      tick(); check32("t5_after", excepttype_o, 32'd1);
      settle(4);

      // 6: bubble with ECALL flag never traps
      @(negedge clk); mem_valid_i = 0; exc_ecall_i = 1;
      repeat (3) begin tick(); check32("t6_bubble", excepttype_o, C_NONE); end
      settle(2);

      // Randomized traffic; the compare process checks every cycle.
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         rst            = ($urandom_range(0, 199) != 0);
         mem_valid_i    = ($urandom_range(0, 3) != 0);
         mem_pc_i       = $urandom;
         mem_inst_i     = $urandom;
         exc_inst_inv_i = ($urandom_range(0, 15) == 0);
         exc_ecall_i    = ($urandom_range(0, 15) == 0);
         exc_ebreak_i   = ($urandom_range(0, 15) == 0);
         exc_ld_mis_i   = ($urandom_range(0, 15) == 0);
         exc_st_mis_i   = ($urandom_range(0, 15) == 0);
         exc_ov_i       = ($urandom_range(0, 15) == 0);
         mret_i         = ($urandom_range(0, 11) == 0);
         timer_int_i    = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 5) == 0) ext_int_i = ~ext_int_i;
         mstatus_i      = $urandom;
         mstatus_i[3]   = ($urandom_range(0, 2) != 0);
         mtvec_i        = $urandom;
         mepc_i         = $urandom;
      end
      settle(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
